// File: rtl/cv32e40p_core_v_xif_pkg.sv
// Shared X-interface types and defaults for the coprocessor result transmitter.
package cv32e40p_core_v_xif_pkg;

  localparam int X_ID_WIDTH       = 4;
  localparam int X_RES_FIFO_DEPTH = 4;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic [4:0]            rd;
    logic [31:0]           data;
    logic                  we;
  } x_result_entry_t;

endpackage

// File: rtl/cv32e40p_x_res_fifo.sv
// First-word-fall-through FIFO of X-interface result entries with phase-bit pointers.
module cv32e40p_x_res_fifo
  import cv32e40p_core_v_xif_pkg::*;
#(
  parameter  int DEPTH = X_RES_FIFO_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            push_i,
  input  x_result_entry_t wdata_i,
  input  logic            pop_i,
  output x_result_entry_t rdata_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [AW:0]     occupancy_o
);

  logic [AW:0]     wr_ptr, rd_ptr;
  x_result_entry_t mem [DEPTH];
  logic            do_push, do_pop;

  assign empty_o = (wr_ptr == rd_ptr);
  assign full_o  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  // Push is gated by full before any same-cycle pop, so a full FIFO never overwrites its head.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is cleared on reset so the head outputs read zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push && !flush_i) begin
      mem[wr_ptr[AW-1:0]] <= wdata_i;
    end
  end

  assign rdata_o     = mem[rd_ptr[AW-1:0]];
  assign occupancy_o = wr_ptr - rd_ptr;

endmodule

// File: rtl/cv32e40p_x_result_tx.sv
// Coprocessor-side X-interface result transmitter: buffered result channel plus
// one-shot register-file write pulses for memory results returned by the core.
module cv32e40p_x_result_tx
  import cv32e40p_core_v_xif_pkg::*;
#(
  parameter int DEPTH    = X_RES_FIFO_DEPTH,
  parameter int ID_WIDTH = X_ID_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush_i,
  input  logic                    cop_res_valid_i,
  output logic                    cop_res_ready_o,
  input  logic [ID_WIDTH-1:0]     cop_res_id_i,
  input  logic [4:0]              cop_res_rd_i,
  input  logic [31:0]             cop_res_data_i,
  input  logic                    cop_res_we_i,
  output logic                    x_result_valid_o,
  input  logic                    x_result_ready_i,
  output logic [ID_WIDTH-1:0]     x_result_id_o,
  output logic [4:0]              x_result_rd_o,
  output logic [31:0]             x_result_data_o,
  output logic                    x_result_we_o,
  input  logic                    x_mem_instr_wb_i,
  input  logic [ID_WIDTH-1:0]     x_mem_result_id_i,
  input  logic [31:0]             x_mem_result_rdata_i,
  output logic                    mem_wb_valid_o,
  output logic [ID_WIDTH-1:0]     mem_wb_id_o,
  output logic [31:0]             mem_wb_data_o,
  output logic [$clog2(DEPTH):0]  occupancy_o
);

  x_result_entry_t wentry, head;
  logic            full, empty;

  // Writes to x0 are architecturally void; drop the enable but still send the result.
  always_comb begin
    wentry      = '0;
    wentry.id   = cop_res_id_i;
    wentry.rd   = cop_res_rd_i;
    wentry.data = cop_res_data_i;
    wentry.we   = cop_res_we_i & (cop_res_rd_i != 5'd0);
  end

  cv32e40p_x_res_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush_i),
    .push_i      (cop_res_valid_i),
    .wdata_i     (wentry),
    .pop_i       (x_result_ready_i),
    .rdata_o     (head),
    .full_o      (full),
    .empty_o     (empty),
    .occupancy_o (occupancy_o)
  );

  assign cop_res_ready_o  = ~full;
  assign x_result_valid_o = ~empty;
  assign x_result_id_o    = head.id;
  assign x_result_rd_o    = head.rd;
  assign x_result_data_o  = head.data;
  assign x_result_we_o    = head.we;

  // A stalled WB stage repeats the same ID; only its first cycle produces a pulse.
  logic                prev_wb;
  logic [ID_WIDTH-1:0] prev_id;
  logic                mem_new;

  assign mem_new = x_mem_instr_wb_i & ~(prev_wb & (prev_id == x_mem_result_id_i));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_wb        <= 1'b0;
      prev_id        <= '0;
      mem_wb_valid_o <= 1'b0;
      mem_wb_id_o    <= '0;
      mem_wb_data_o  <= '0;
    end else begin
      prev_wb        <= x_mem_instr_wb_i;
      prev_id        <= x_mem_result_id_i;
      mem_wb_valid_o <= mem_new;
      if (mem_new) begin
        mem_wb_id_o   <= x_mem_result_id_i;
        mem_wb_data_o <= x_mem_result_rdata_i;
      end
    end
  end

endmodule

// File: doc/cv32e40p_x_result_tx.md
Name: cv32e40p_x_result_tx

Overview:
- Coprocessor-side transmitter for the X-interface result channel. Buffers writeback results from the coprocessor pipeline in an in-order FIFO and presents them to the core's EX stage (x_result_valid/rd/data/we).
- Also receives the core's memory-result writeback (x_mem_instr_wb, x_mem_result_id, load data) and turns each new one into a single-cycle write pulse for the coprocessor register file.

Parameters:
- DEPTH, 4, result FIFO entries; power of two, at least 2.
- ID_WIDTH, 4, instruction ID width; must match the core's x_mem_result_id width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- flush_i  in  1  synchronous flush of all buffered results
- cop_res_valid_i  in  1  coprocessor pipeline offers a result
- cop_res_ready_o  out  1  FIFO accepts the result
- cop_res_id_i  in  ID_WIDTH  instruction ID
- cop_res_rd_i  in  5  destination GPR
- cop_res_data_i  in  32  result data
- cop_res_we_i  in  1  result writes a GPR
- x_result_valid_o  out  1  result offered to core
- x_result_ready_i  in  1  core accepts the result
- x_result_id_o  out  ID_WIDTH  head ID
- x_result_rd_o  out  5  head rd
- x_result_data_o  out  32  head data
- x_result_we_o  out  1  head write enable
- x_mem_instr_wb_i  in  1  core WB stage holds a coprocessor memory instruction
- x_mem_result_id_i  in  ID_WIDTH  ID of that instruction
- x_mem_result_rdata_i  in  32  load data from core
- mem_wb_valid_o  out  1  one-cycle coprocessor RF write pulse
- mem_wb_id_o  out  ID_WIDTH  ID for the RF write
- mem_wb_data_o  out  32  load data for the RF write
- occupancy_o  out  $clog2(DEPTH)+1  current FIFO fill level

Behaviour:
Reset and clocking:
- Reset is rst_n, asynchronous, active-low; clock is clk.
- On reset: FIFO empty, pointers 0. x_result_valid_o=0; x_result_id_o/rd_o/data_o/we_o=0; cop_res_ready_o=1; mem_wb_valid_o=0; mem_wb_id_o=0; mem_wb_data_o=0; occupancy_o=0.
- Reset mid-transfer discards all buffered entries and any pending mem pulse.

Result FIFO (first-word-fall-through):
- Read and write pointers are log2(DEPTH)+1 bits, wrapping with an extra phase bit.
- Empty when the pointers are equal. Full when the low bits are equal and the phase bits differ.
- cop_res_ready_o = ~full. It does not depend on x_result_ready_i, so there is no combinational path core→coprocessor.
- Push happens when cop_res_valid_i & cop_res_ready_o. The entry is visible at the output the cycle after the push; minimum latency is 1 cycle.
- x_result_valid_o = ~empty. Outputs come from the head entry, driven from registers/storage only, never from cop_res_*_i.
- Pop happens when x_result_valid_o & x_result_ready_i.
- Push and pop in the same cycle: both take effect and occupancy is unchanged. When full, a same-cycle pop does not enable a push.
- While valid & ~ready, head outputs hold stable. The valid→ready rule is AXI-like: valid never drops without a handshake, except on flush.
- rd=0 rule: an entry pushed with rd=0 and we=1 is stored with we=0. It is still transmitted.

Flush:
- flush_i=1 empties the FIFO at the next edge and takes priority over a same-cycle push.
- x_result_valid_o is 0 in the cycle after the flush edge.
- The mem path is unaffected by flush.

Memory-result path:
- Registered state: prev_wb and prev_id.
- A new memory result is x_mem_instr_wb_i & ~(prev_wb & prev_id==x_mem_result_id_i). This yields exactly one pulse per WB residency, even when the core stalls WB for several cycles.
- On a new memory result, the next cycle shows mem_wb_valid_o=1 with mem_wb_id_o and mem_wb_data_o captured from that cycle. Latency is 1 cycle and the pulse width is 1 cycle.
- Back-to-back instructions with different IDs produce consecutive pulses.
- The same ID in consecutive WB cycles counts as one instruction.

occupancy_o:
- Equals wr_ptr − rd_ptr, registered via the pointers.

Decomposition:
- Add x_result_entry_t to cv32e40p_core_v_xif_pkg: struct {id, rd, data, we}.
- Add to the same package: the X_ID_WIDTH constant (default 4) and X_RES_FIFO_DEPTH (default 4).
- Sub-module cv32e40p_x_res_fifo: generic FWFT FIFO carrying x_result_entry_t, with the full/empty/occupancy logic.
- The top level holds the handshake mapping, the rd=0 we-masking, and the mem-result pulse logic.

Test Plan:
1. Single result: push id=3, rd=5, data=0xDEADBEEF, we=1 with ready_i=1. The next cycle shows x_result_valid_o=1 with those values; the following cycle valid=0 and occupancy_o=0.
2. Fill and backpressure: hold ready_i=0 and push 4 entries (data 1..4). cop_res_ready_o=0 after the 4th and occupancy_o=4. A 5th push attempt is not accepted. Releasing ready_i drains data 1,2,3,4 in order on consecutive cycles.
3. Simultaneous push/pop at occupancy 2 for 3 cycles: occupancy stays at 2 and output order is preserved. With a full FIFO plus pop plus valid push in the same cycle, the push is rejected.
4. rd=0 masking and flush: push rd=0, we=1 → output shows we_o=0. Push 3 entries, then assert flush_i together with a 4th push → the next cycle shows valid=0, occupancy 0, and the 4th entry is absent.
5. Mem path: x_mem_instr_wb_i=1, id=7, rdata=0x1234 held for 3 cycles → exactly one mem_wb_valid_o pulse with id=7, data=0x1234. Then id=8 on the next cycle → a second pulse.
6. Reset mid-operation: with 3 entries queued and valid high, assert rst_n=0 asynchronously → all outputs drop to their reset values immediately, and after release occupancy_o=0.
